// File: rtl/axis_pkg.sv
// Shared AXI4-Stream byte-lane definitions: lane width, word struct and keep-mask helper.
package axis_pkg;

  localparam int AXIS_BYTE_W = 8;
  localparam int AXIS_RATIO  = 4;
  localparam int AXIS_WORD_W = AXIS_BYTE_W * AXIS_RATIO;

  typedef struct packed {
    logic [AXIS_WORD_W-1:0] tdata;
    logic [AXIS_RATIO-1:0]  tkeep;
    logic                   tlast;
  } axis_word_t;

  // Contiguous lane mask with the lowest n lanes set.
  function automatic logic [AXIS_RATIO-1:0] keep_mask(input int n);
    logic [AXIS_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < AXIS_RATIO; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_upsizer_acc.sv
// Byte accumulator for the upsizer: collects lanes and presents the merged word on a closing beat.
module axis_upsizer_acc
  import axis_pkg::*;
#(
  parameter int IN_W  = AXIS_BYTE_W,
  parameter int RATIO = AXIS_RATIO
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  tvalid,
  input  logic [IN_W-1:0]       tdata,
  input  logic                  tkeep,
  input  logic                  tlast,
  input  logic                  beat,
  output logic                  close_pending,
  output logic [IN_W*RATIO-1:0] merged_data,
  output logic [RATIO-1:0]      merged_keep
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IDX_W-1:0]       idx;
  logic [IN_W*RATIO-1:0]  acc_data;

  // A beat closes the word when it fills the last lane or ends the packet.
  assign close_pending = tvalid & ((tkeep & (idx == IDX_W'(RATIO - 1))) | tlast);

  // Lanes at and above idx are always zero in acc_data, so unused lanes stay clear.
  always_comb begin
    merged_data = acc_data;
    if (tkeep) begin
      merged_data[idx*IN_W +: IN_W] = tdata;
    end
  end

  assign merged_keep = keep_mask(int'(idx) + int'(tkeep));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx      <= '0;
      acc_data <= '0;
    end else if (beat) begin
      if (close_pending) begin
        idx      <= '0;
        acc_data <= '0;
      end else if (tkeep) begin
        acc_data[idx*IN_W +: IN_W] <= tdata;
        idx                        <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_byte_upsizer.sv
// Packs an 8-bit AXI4-Stream into 32-bit words, flushing partial words on tlast.
module axis_byte_upsizer
  import axis_pkg::*;
#(
  parameter int IN_W  = AXIS_BYTE_W,
  parameter int RATIO = AXIS_RATIO,
  parameter int CNT_W = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [IN_W-1:0]       s_axis_tdata,
  input  logic                  s_axis_tkeep,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [IN_W*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]      m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [CNT_W-1:0]      pkt_count
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // a source holding valid keeps its payload stable until ready, and ready may depend on valid.

  logic                  aresetn_q;
  logic                  close_pending;
  logic                  s_beat;
  logic                  m_beat;
  logic [IN_W*RATIO-1:0] merged_data;
  logic [RATIO-1:0]      merged_keep;
  axis_word_t            out_q;
  logic                  out_valid;

  axis_upsizer_acc #(
    .IN_W  (IN_W),
    .RATIO (RATIO)
  ) u_acc (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .tvalid        (s_axis_tvalid),
    .tdata         (s_axis_tdata),
    .tkeep         (s_axis_tkeep),
    .tlast         (s_axis_tlast),
    .beat          (s_beat),
    .close_pending (close_pending),
    .merged_data   (merged_data),
    .merged_keep   (merged_keep)
  );

  // Only a closing beat needs the output register; everything else fits in the accumulator.
  assign s_axis_tready = aresetn_q & (~close_pending | ~out_valid | m_axis_tready);
  assign s_beat        = s_axis_tvalid & s_axis_tready;
  assign m_beat        = out_valid & m_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aresetn_q <= 1'b0;
      out_q     <= '0;
      out_valid <= 1'b0;
      pkt_count <= '0;
    end else begin
      aresetn_q <= 1'b1;
      if (s_beat && close_pending) begin
        out_q.tdata <= merged_data;
        out_q.tkeep <= merged_keep;
        out_q.tlast <= s_axis_tlast;
        out_valid   <= 1'b1;
      end else if (m_beat) begin
        out_valid <= 1'b0;
      end
      if (m_beat && out_q.tlast) begin
        pkt_count <= pkt_count + 1'b1;
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_q.tdata;
  assign m_axis_tkeep  = out_q.tkeep;
  assign m_axis_tlast  = out_q.tlast;

endmodule
